// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a 16x8 fifo between two
// producers. Each grant lasts for a burst of up to BURST words. The arbiter never
// writes while the fifo reports full, and a full fifo never forces a switch.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    input  logic             fifo_full,
    output logic             fifo_wr_enb,
    output logic [WIDTH-1:0] fifo_data_in,
    output logic             owner,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] BURST_C = CNTW'(BURST);

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            cur_is1;
    logic            my_req;
    logic            oth_req;
    logic            my_ack;
    logic [CNTW-1:0] cnt_inc;

    // Outputs: a single gating level on top of the registered state
    assign ack0         = (state_q == OWN0) & req0 & ~fifo_full;
    assign ack1         = (state_q == OWN1) & req1 & ~fifo_full;
    assign fifo_wr_enb  = ack0 | ack1;
    assign fifo_data_in = ack0 ? data0 : (ack1 ? data1 : '0);
    assign owner        = last_q;
    assign busy         = (state_q != IDLE);

    assign cur_is1 = (state_q == OWN1);
    assign my_req  = cur_is1 ? req1 : req0;
    assign oth_req = cur_is1 ? req0 : req1;
    assign my_ack  = ack0 | ack1;
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state: grant selection in IDLE, burst counting and hand-over in OWNx
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (req0) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                // A producer releasing its request ends the grant even while full;
                // full alone only stalls.
                if (!my_req) begin
                    cnt_d = '0;
                    if (oth_req) begin
                        state_d = cur_is1 ? OWN0 : OWN1;
                        last_d  = ~cur_is1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (my_ack) begin
                    if (cnt_inc == BURST_C) begin
                        cnt_d = '0;
                        if (oth_req) begin
                            state_d = cur_is1 ? OWN0 : OWN1;
                            last_d  = ~cur_is1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; last resets to 1 so producer 0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
